multicycle_control: RTL and testbench
=====================================

# multicycle_control

Parametrised multi-cycle control unit for the MIPS-subset CPU. It supports the same instruction set as the single-cycle control LUT (LW, SW, J, JAL, BEQ, BNE, XORI, ADDI, JR, ADD, SUB, SLT), sequenced over FETCH/DECODE/EXEC/MEM/WB states. It shares one memory port for instruction and data, tolerates variable-latency memory through a ready handshake, and enforces a bus timeout. It adds illegal-instruction trapping and a retired-instruction counter. It drives the PC, IR, regfile, ALU and memory datapath muxes.

## Interface
- MEM_TIMEOUT, 16: maximum cycles to wait for mem_ready in one access; range 1..2^TO_W-1.
- TO_W, 8: timeout counter width.
- CNT_W, 32: width of the retired-instruction counter.
- clk  in  1  sole clock; all state changes on posedge clk.
- reset  in  1  synchronous, active-high.
- opcode  in  6  instruction[31:26] from the decoder; valid from DECODE onward.
- funct  in  6  instruction[5:0].
- alu_zero  in  1  ALU zero flag; sampled combinationally in EXEC.
- mem_ready  in  1  memory completes the current access this cycle.
- pc_wr  out  1  PC load strobe.
- pc_src  out  2  0=PC+4, 1=branch target, 2=jump target, 3=register Da (JR).
- ir_wr  out  1  IR load strobe.
- i_or_d  out  1  memory address: 0=PC, 1=ALU result register.
- mem_rd, mem_wr  out  1 each  memory strobes.
- reg_wr  out  1  regfile write enable.
- reg_dst  out  2  0=rd, 1=rt, 2=r31.
- mem_to_reg  out  2  0=ALU result, 1=memory data register, 2=PC (already PC+4).
- alu_src_b  out  1  0=Db, 1=sign-extended immediate.
- alu_ctrl  out  3  000 add, 001 sub, 010 xor, 011 slt.
- trap  out  1  illegal instruction or bus timeout; sticky.
- trap_cause  out  1  0=illegal, 1=timeout; valid while trap=1.
- state  out  3  current state encoding (debug).
- instret  out  CNT_W  count of retired instructions, wraps modulo 2^CNT_W.

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7. All outputs are combinational in state, the latched class, mem_ready and alu_zero. Outputs not listed for a state are 0.
- FETCH: mem_rd=1, i_or_d=0. On mem_ready: ir_wr=1, pc_wr=1, pc_src=0, next state DECODE. Otherwise stay.
- DECODE: latch the instruction class from opcode/funct.
  - Illegal (any other opcode, or ARITH with any other funct): go to TRAP, trap_cause=0.
  - J: pc_wr=1, pc_src=2, then FETCH; retire.
  - JAL: same as J, plus reg_wr=1, reg_dst=2, mem_to_reg=2; retire.
  - JR: pc_wr=1, pc_src=3, then FETCH; retire.
  - Others: go to EXEC.
- EXEC: alu_ctrl and alu_src_b by class: LW/SW/ADDI add,imm; XORI xor,imm; ADD/SUB/SLT add/sub/slt,Db; BEQ/BNE sub,Db.
  - BEQ: pc_wr=alu_zero. BNE: pc_wr=!alu_zero. pc_src=1 for both, then FETCH; retire.
  - LW/SW: go to MEM. ALU classes: go to WB.
- MEM: i_or_d=1; LW asserts mem_rd, SW asserts mem_wr.
  - On mem_ready: LW goes to WB; SW goes to FETCH and retires.
- WB: reg_wr=1.
  - LW: reg_dst=1, mem_to_reg=1. ADDI/XORI: reg_dst=1, mem_to_reg=0. R-type: reg_dst=0, mem_to_reg=0.
  - Then FETCH; retire.
- Timeout: the counter clears on entry to FETCH or MEM and increments each cycle mem_ready=0 in those states. When the count reaches MEM_TIMEOUT with mem_ready still 0, go to TRAP with trap_cause=1. No strobe fires in that cycle.
- TRAP: all strobes 0, trap=1, held until reset. instret frozen.
- Retire: instret increments by 1 on the cycle the instruction's final state exits.

## Timing
- Reset cycle: all strobes 0, state=FETCH, instret=0, trap=0, timeout counter=0. The first fetch strobe asserts the cycle after reset deasserts.
- Reset mid-instruction aborts it: no retire, all strobes 0 that cycle.
- Minimum CPI with zero-wait memory: J/JAL/JR 2; BEQ/BNE 3; ALU ops 4; SW 4; LW 5. Each wait cycle adds 1 to the relevant state.
- mem_ready outside FETCH/MEM is ignored.
- mem_ready=1 on the exact cycle count==MEM_TIMEOUT completes normally; a ready arriving at the same time as the deadline wins.
- Illegal opcode: exactly one DECODE cycle, then TRAP.

## Test plan
- Reset, then ADD with mem_ready tied high -> states 0,1,2,4,0. reg_wr=1 and reg_dst=0 in WB. instret=1 after 4 cycles.
- LW with mem_ready low 3 cycles in FETCH and 2 in MEM -> 10 cycles total. mem_rd held throughout waits. WB shows reg_dst=1, mem_to_reg=1.
- BEQ with alu_zero=1 -> pc_wr=1, pc_src=1 in EXEC. Same with BNE -> pc_wr=0. Both retire.
- JAL -> DECODE shows pc_wr=1, pc_src=2, reg_wr=1, reg_dst=2, mem_to_reg=2. 2-cycle CPI.
- Opcode 6'h3f -> TRAP after DECODE, trap=1, trap_cause=0. Strobes stay 0 for 20 cycles. Reset then clears trap.
- MEM_TIMEOUT=4 with mem_ready never asserted -> TRAP after the 4th wait cycle of FETCH, trap_cause=1. Repeat with ready on cycle 4 -> normal DECODE.

Source files
------------

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM for the MIPS-subset CPU: sequences FETCH/DECODE/EXEC/MEM/WB
// over a shared ready-handshaked memory port, with bus timeout, illegal-op trap and instret.
module multicycle_control #(
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = 8,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             alu_zero,
    input  logic             mem_ready,
    output logic             pc_wr,
    output logic [1:0]       pc_src,
    output logic             ir_wr,
    output logic             i_or_d,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             reg_wr,
    output logic [1:0]       reg_dst,
    output logic [1:0]       mem_to_reg,
    output logic             alu_src_b,
    output logic [2:0]       alu_ctrl,
    output logic             trap,
    output logic             trap_cause,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd7
    } state_t;

    typedef enum logic [3:0] {
        C_LW, C_SW, C_J, C_JAL, C_BEQ, C_BNE, C_XORI,
        C_ADDI, C_JR, C_ADD, C_SUB, C_SLT, C_ILL
    } class_t;

    state_t            state_q, state_d;
    class_t            class_q, dec_class;
    logic [TO_W-1:0]   cnt_q;
    logic [CNT_W-1:0]  instret_q;
    logic              cause_q, cause_d;
    logic              retire;
    logic              waiting, timeout_hit;

    always_comb begin
        dec_class = C_ILL;
        case (opcode)
            6'h23: dec_class = C_LW;
            6'h2b: dec_class = C_SW;
            6'h02: dec_class = C_J;
            6'h03: dec_class = C_JAL;
            6'h04: dec_class = C_BEQ;
            6'h05: dec_class = C_BNE;
            6'h0e: dec_class = C_XORI;
            6'h08: dec_class = C_ADDI;
            6'h00: begin
                case (funct)
                    6'h08:   dec_class = C_JR;
                    6'h20:   dec_class = C_ADD;
                    6'h22:   dec_class = C_SUB;
                    6'h2a:   dec_class = C_SLT;
                    default: dec_class = C_ILL;
                endcase
            end
            default: dec_class = C_ILL;
        endcase
    end

    // A ready arriving on the deadline cycle wins, so the trap needs ready still low.
    assign waiting     = (state_q == FETCH || state_q == MEM) && !mem_ready;
    assign timeout_hit = waiting && (cnt_q == TO_W'(MEM_TIMEOUT));

    always_comb begin
        state_d    = state_q;
        cause_d    = cause_q;
        retire     = 1'b0;
        pc_wr      = 1'b0;
        pc_src     = 2'd0;
        ir_wr      = 1'b0;
        i_or_d     = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        reg_wr     = 1'b0;
        reg_dst    = 2'd0;
        mem_to_reg = 2'd0;
        alu_src_b  = 1'b0;
        alu_ctrl   = 3'b000;
        if (!reset) begin
            case (state_q)
                FETCH: begin
                    if (timeout_hit) begin
                        state_d = TRAP;
                        cause_d = 1'b1;
                    end else begin
                        mem_rd = 1'b1;
                        if (mem_ready) begin
                            ir_wr   = 1'b1;
                            pc_wr   = 1'b1;
                            state_d = DECODE;
                        end
                    end
                end
                DECODE: begin
                    case (dec_class)
                        C_ILL: begin
                            state_d = TRAP;
                            cause_d = 1'b0;
                        end
                        C_J: begin
                            pc_wr   = 1'b1;
                            pc_src  = 2'd2;
                            state_d = FETCH;
                            retire  = 1'b1;
                        end
                        C_JAL: begin
                            pc_wr      = 1'b1;
                            pc_src     = 2'd2;
                            reg_wr     = 1'b1;
                            reg_dst    = 2'd2;
                            mem_to_reg = 2'd2;
                            state_d    = FETCH;
                            retire     = 1'b1;
                        end
                        C_JR: begin
                            pc_wr   = 1'b1;
                            pc_src  = 2'd3;
                            state_d = FETCH;
                            retire  = 1'b1;
                        end
                        default: state_d = EXEC;
                    endcase
                end
                EXEC: begin
                    case (class_q)
                        C_LW, C_SW: begin
                            alu_src_b = 1'b1;
                            state_d   = MEM;
                        end
                        C_ADDI: begin
                            alu_src_b = 1'b1;
                            state_d   = WB;
                        end
                        C_XORI: begin
                            alu_src_b = 1'b1;
                            alu_ctrl  = 3'b010;
                            state_d   = WB;
                        end
                        C_ADD: state_d = WB;
                        C_SUB: begin
                            alu_ctrl = 3'b001;
                            state_d  = WB;
                        end
                        C_SLT: begin
                            alu_ctrl = 3'b011;
                            state_d  = WB;
                        end
                        C_BEQ, C_BNE: begin
                            alu_ctrl = 3'b001;
                            pc_src   = 2'd1;
                            pc_wr    = (class_q == C_BEQ) ? alu_zero : !alu_zero;
                            state_d  = FETCH;
                            retire   = 1'b1;
                        end
                        default: begin
                            state_d = TRAP;
                            cause_d = 1'b0;
                        end
                    endcase
                end
                MEM: begin
                    if (timeout_hit) begin
                        state_d = TRAP;
                        cause_d = 1'b1;
                    end else begin
                        i_or_d = 1'b1;
                        mem_rd = (class_q == C_LW);
                        mem_wr = (class_q == C_SW);
                        if (mem_ready) begin
                            state_d = (class_q == C_LW) ? WB : FETCH;
                            retire  = (class_q == C_SW);
                        end
                    end
                end
                WB: begin
                    reg_wr = 1'b1;
                    case (class_q)
                        C_LW: begin
                            reg_dst    = 2'd1;
                            mem_to_reg = 2'd1;
                        end
                        C_ADDI, C_XORI: reg_dst = 2'd1;
                        default:        reg_dst = 2'd0;
                    endcase
                    state_d = FETCH;
                    retire  = 1'b1;
                end
                TRAP:    state_d = TRAP;
                default: state_d = FETCH;
            endcase
        end
    end

    // The wait counter restarts whenever the state changes, which covers entry to FETCH and MEM.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FETCH;
            class_q   <= C_ILL;
            cnt_q     <= '0;
            instret_q <= '0;
            cause_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            if (state_q == DECODE) begin
                class_q <= dec_class;
            end
            if (waiting && !timeout_hit) begin
                cnt_q <= cnt_q + TO_W'(1);
            end else begin
                cnt_q <= '0;
            end
            if (retire) begin
                instret_q <= instret_q + CNT_W'(1);
            end
        end
    end

    assign state      = reset ? FETCH : state_q;
    assign trap       = !reset && (state_q == TRAP);
    assign trap_cause = trap && cause_q;
    assign instret    = reset ? '0 : instret_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Cycle-by-cycle vector bench for multicycle_control: table of per-cycle inputs and
// hand-computed outputs, plus a hand-written trap-hold and recovery sequence.
module tb_multicycle_control;

    logic        clk;
    logic        reset;
    logic [5:0]  opcode, funct;
    logic        alu_zero, mem_ready;
    logic        pc_wr, ir_wr, i_or_d, mem_rd, mem_wr, reg_wr, alu_src_b, trap, trap_cause;
    logic [1:0]  pc_src, reg_dst, mem_to_reg;
    logic [2:0]  alu_ctrl, state;
    logic [31:0] instret;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic        rst;
        logic [5:0]  op, fn;
        logic        z, rdy;
        logic [20:0] out;
        logic [31:0] ir;
    } vec_t;

    vec_t vecs[$];

    multicycle_control #(.MEM_TIMEOUT(4), .TO_W(8), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
        .alu_zero(alu_zero), .mem_ready(mem_ready),
        .pc_wr(pc_wr), .pc_src(pc_src), .ir_wr(ir_wr), .i_or_d(i_or_d),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .reg_wr(reg_wr), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl),
        .trap(trap), .trap_cause(trap_cause), .state(state), .instret(instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Argument order: inputs, then st,pcw,pcs,irw,iod,mrd,mwr,rw,rd,m2r,asb,alu,trp,tc, then instret.
    function automatic void add(int rst, int op, int fn, int z, int rdy,
                                int st, int pcw, int pcs, int irw, int iod, int mrd,
                                int mwr, int rw, int rd, int m2r, int asb, int alu,
                                int trp, int tc, int ir);
        vec_t v;
        v.rst = rst[0];
        v.op  = 6'(op);
        v.fn  = 6'(fn);
        v.z   = z[0];
        v.rdy = rdy[0];
        v.out = {pcw[0], 2'(pcs), irw[0], iod[0], mrd[0], mwr[0], rw[0], 2'(rd), 2'(m2r),
                 asb[0], 3'(alu), trp[0], tc[0], 3'(st)};
        v.ir  = 32'(ir);
        vecs.push_back(v);
    endfunction

    function automatic void fetch_row(int op, int fn, int rdy, int ir);
        add(0, op, fn, 0, rdy, 0, rdy, 0, rdy, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, ir);
    endfunction

    function automatic void decode_row(int op, int fn, int ir);
        add(0, op, fn, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ir);
    endfunction

    function automatic void reset_row();
        add(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic void build_table();
        reset_row();
        reset_row();
        // ADD, zero-wait
        fetch_row(0, 'h20, 1, 0);
        decode_row(0, 'h20, 0);
        add(0, 0, 'h20, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 'h20, 0, 1, 4, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        // LW, 3 fetch waits and 2 mem waits
        for (int i = 0; i < 3; i++) fetch_row('h23, 0, 0, 1);
        fetch_row('h23, 0, 1, 1);
        decode_row('h23, 0, 1);
        add(0, 'h23, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
        add(0, 'h23, 0, 0, 0, 3, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        add(0, 'h23, 0, 0, 0, 3, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        add(0, 'h23, 0, 0, 1, 3, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        add(0, 'h23, 0, 0, 1, 4, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 1);
        // BEQ taken
        fetch_row('h04, 0, 1, 2);
        decode_row('h04, 0, 2);
        add(0, 'h04, 0, 1, 1, 2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2);
        // BNE with zero set: not taken
        fetch_row('h05, 0, 1, 3);
        decode_row('h05, 0, 3);
        add(0, 'h05, 0, 1, 1, 2, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 3);
        // JAL
        fetch_row('h03, 0, 1, 4);
        add(0, 'h03, 0, 0, 1, 1, 1, 2, 0, 0, 0, 0, 1, 2, 2, 0, 0, 0, 0, 4);
        // SW
        fetch_row('h2b, 0, 1, 5);
        decode_row('h2b, 0, 5);
        add(0, 'h2b, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 5);
        add(0, 'h2b, 0, 0, 1, 3, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 5);
        // XORI
        fetch_row('h0e, 0, 1, 6);
        decode_row('h0e, 0, 6);
        add(0, 'h0e, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 6);
        add(0, 'h0e, 0, 0, 1, 4, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 6);
        // JR
        fetch_row(0, 'h08, 1, 7);
        add(0, 0, 'h08, 0, 1, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7);
        // ADDI
        fetch_row('h08, 0, 1, 8);
        decode_row('h08, 0, 8);
        add(0, 'h08, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 8);
        add(0, 'h08, 0, 0, 1, 4, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 8);
        // SUB
        fetch_row(0, 'h22, 1, 9);
        decode_row(0, 'h22, 9);
        add(0, 0, 'h22, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 9);
        add(0, 0, 'h22, 0, 1, 4, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 9);
        // SLT
        fetch_row(0, 'h2a, 1, 10);
        decode_row(0, 'h2a, 10);
        add(0, 0, 'h2a, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 10);
        add(0, 0, 'h2a, 0, 1, 4, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 10);
        // BNE with zero clear: taken
        fetch_row('h05, 0, 1, 11);
        decode_row('h05, 0, 11);
        add(0, 'h05, 0, 0, 1, 2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 11);
        // ready also ignored outside FETCH/MEM: first fetch after the BNE shows instret 12
        fetch_row(0, 'h20, 1, 12);
        reset_row();
        // FETCH timeout: 4 waits, deadline with ready low, then TRAP cause 1
        for (int i = 0; i < 4; i++) fetch_row(0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        reset_row();
        // ARITH with illegal funct
        fetch_row(0, 'h3f, 1, 0);
        decode_row(0, 'h3f, 0);
        add(0, 0, 'h3f, 0, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        reset_row();
        // LW stalled in MEM until timeout
        fetch_row('h23, 0, 1, 0);
        decode_row('h23, 0, 0);
        add(0, 'h23, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            add(0, 'h23, 0, 0, 0, 3, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 'h23, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 'h23, 0, 0, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        reset_row();
        // ready on the deadline cycle completes, then opcode 3f traps as illegal
        for (int i = 0; i < 4; i++) fetch_row('h3f, 0, 0, 0);
        fetch_row('h3f, 0, 1, 0);
        decode_row('h3f, 0, 0);
        add(0, 'h3f, 0, 0, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    endfunction

    task automatic apply_stimulus(input vec_t v);
        reset     = v.rst;
        opcode    = v.op;
        funct     = v.fn;
        alu_zero  = v.z;
        mem_ready = v.rdy;
    endtask

    task automatic check_output(input int idx, input vec_t v);
        logic [20:0] got;
        got = {pc_wr, pc_src, ir_wr, i_or_d, mem_rd, mem_wr, reg_wr, reg_dst, mem_to_reg,
               alu_src_b, alu_ctrl, trap, trap_cause, state};
        tests_run++;
        if (got !== v.out) begin
            tests_failed++;
            $display("[TB] FAIL row%0d outputs: got %b expected %b", idx, got, v.out);
        end
        tests_run++;
        if (instret !== v.ir) begin
            tests_failed++;
            $display("[TB] FAIL row%0d instret: got %0d expected %0d", idx, instret, v.ir);
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        opcode = '0;
        funct = '0;
        alu_zero = 1'b0;
        mem_ready = 1'b0;
        build_table();
        foreach (vecs[i]) begin
            @(negedge clk);
            apply_stimulus(vecs[i]);
            #1;
            check_output(i, vecs[i]);
        end

        // Trap must hold with no strobes regardless of inputs.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            mem_ready = 1'($urandom_range(0, 1));
            alu_zero  = 1'($urandom_range(0, 1));
            opcode    = 6'($urandom_range(0, 63));
            #1;
            check_val("trap_hold", 32'({pc_wr, ir_wr, mem_rd, mem_wr, reg_wr, trap, trap_cause, state}),
                      32'({5'b0, 1'b1, 1'b0, 3'd7}));
        end

        // Reset clears the trap, then a J runs normally.
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_val("reset_clears_trap", 32'({trap, state}), 32'({1'b0, 3'd0}));
        @(negedge clk);
        reset = 1'b0;
        opcode = 6'h02;
        funct = 6'h00;
        mem_ready = 1'b1;
        #1;
        check_val("post_trap_fetch", 32'({mem_rd, ir_wr, pc_wr, state}), 32'({3'b111, 3'd0}));
        @(negedge clk);
        #1;
        check_val("j_decode", 32'({pc_wr, pc_src, reg_wr, state}), 32'({1'b1, 2'd2, 1'b0, 3'd1}));
        @(negedge clk);
        #1;
        check_val("j_retired", instret, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
